// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with architectural HI/LO registers.
// Decodes the R-type MULT/MULTU/DIV/DIVU/MTHI/MTLO funct codes. Multiply is
// radix-2 shift-add and divide is restoring, both one bit per cycle over
// WIDTH iterations. A final FIX cycle applies the signs and writes HI/LO.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start, funct     request and its R-type function field (taken when busy=0)
//   rs_val, rt_val   operands (multiplicand/dividend, multiplier/divisor)
//   busy             operation in flight, core must stall
//   done             one-cycle pulse when hi/lo carry a new result
//   dz               divide-by-zero flag, only meaningful with done
//   hi, lo           HI/LO registers
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; MTHI/MTLO are written directly here
// MUL   | WIDTH shift-add iterations on the product register
// DIV   | WIDTH restoring-divide iterations, one quotient bit each
// FIX   | sign correction / divide-by-zero override, HI/LO write
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  // MUL: {partial product, remaining multiplier bits}
  // DIV: {partial remainder, dividend bits shifting out / quotient shifting in}
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   opb;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   rs_cap;  // raw dividend, returned in HI on divide by zero
  logic               neg_q;   // product / quotient must be negated
  logic               neg_r;   // remainder must be negated
  logic               is_div;
  logic               div_zero;

  logic               is_mul_op, is_div_op, is_signed;
  logic               acc_long, acc_mthi, acc_mtlo;
  logic               rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix, hi_fix, lo_fix;

  // Request decode; only IDLE accepts, and busy is low exactly in IDLE.
  always_comb begin
    is_mul_op = (funct == F_MULT) || (funct == F_MULTU);
    is_div_op = (funct == F_DIV)  || (funct == F_DIVU);
    is_signed = ~funct[0];
    acc_long  = start && !busy && (is_mul_op || is_div_op);
    acc_mthi  = start && !busy && (funct == F_MTHI);
    acc_mtlo  = start && !busy && (funct == F_MTLO);
    rs_neg    = is_signed && rs_val[WIDTH-1];
    rt_neg    = is_signed && rt_val[WIDTH-1];
    rs_mag    = rs_neg ? -rs_val : rs_val;
    rt_mag    = rt_neg ? -rt_val : rt_val;
  end

  // One iteration of each algorithm.
  always_comb begin
    mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, opb} : '0);
    mul_next  = {mul_sum, p[WIDTH-1:1]};
    div_shift = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    div_ge    = (div_shift >= {1'b0, opb});
    div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 p[WIDTH-2:0], div_ge};
  end

  // Final result selection in FIX.
  always_comb begin
    prod_fix = neg_q ? -p : p;
    q_fix    = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    r_fix    = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    if (!is_div) begin
      hi_fix = prod_fix[2*WIDTH-1:WIDTH];
      lo_fix = prod_fix[WIDTH-1:0];
    end else if (div_zero) begin
      hi_fix = rs_cap;
      lo_fix = '1;
    end else begin
      hi_fix = r_fix;
      lo_fix = q_fix;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (acc_long) state_nxt = is_mul_op ? MUL : DIV;
      MUL:  if (cnt == CNT_LAST) state_nxt = FIX;
      DIV:  if (cnt == CNT_LAST) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      p        <= '0;
      opb      <= '0;
      rs_cap   <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dz       <= 1'b0;
    end else begin
      done <= 1'b0;
      dz   <= 1'b0;
      case (state)
        IDLE: begin
          if (acc_long) begin
            // Multiply shifts the multiplier out of the low half; divide
            // shifts the dividend out of the low half.
            p        <= {{WIDTH{1'b0}}, (is_mul_op ? rt_mag : rs_mag)};
            opb      <= is_mul_op ? rs_mag : rt_mag;
            rs_cap   <= rs_val;
            neg_q    <= rs_neg ^ rt_neg;
            neg_r    <= rs_neg;
            is_div   <= is_div_op;
            div_zero <= is_div_op && (rt_val == '0);
            cnt      <= '0;
            busy     <= 1'b1;
          end else if (acc_mthi) begin
            hi <= rs_val;
          end else if (acc_mtlo) begin
            lo <= rs_val;
          end
        end
        MUL: begin
          p   <= mul_next;
          cnt <= cnt + CW'(1);
        end
        DIV: begin
          p   <= div_next;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          hi   <= hi_fix;
          lo   <= lo_fix;
          busy <= 1'b0;
          done <= 1'b1;
          dz   <= is_div && div_zero;
          cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (WIDTH=32). Stimulus pushes the expected
// {hi, lo, dz} of every long operation into a queue; a monitor pops and
// compares each time done is seen.
module tb_mdu_iter;
  localparam int W = 32;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [5:0]   funct = 6'd0;
  logic [W-1:0] rs_val = '0;
  logic [W-1:0] rt_val = '0;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;
  exp_t expq[$];

  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .funct(funct),
    .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares the result every time done is presented.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done: hi=0x%08h lo=0x%08h dz=%0b, no result expected", hi, lo, dz);
        end else begin
          exp_t e;
          e = expq.pop_front();
          if (hi !== e.hi || lo !== e.lo || dz !== e.dz) begin
            failures++;
            $display("FAIL result: got hi=0x%08h lo=0x%08h dz=%0b expected hi=0x%08h lo=0x%08h dz=%0b",
                     hi, lo, dz, e.hi, e.lo, e.dz);
          end
        end
      end else begin
        checks++;
        if (dz !== 1'b0) begin
          failures++;
          $display("FAIL dz_without_done: got dz=%0b expected 0", dz);
        end
      end
    end
  end

  // Waits (bounded) for done, counting negedges with busy high before it.
  task automatic wait_done(output int nb);
    bit seen;
    nb = 0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) nb++;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL done_timeout: got no done within 100 cycles, expected a pulse");
    end
  endtask

  task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed);
    int nb0, nb1;
    expq.push_back('{hi: eh, lo: el, dz: ed});
    @(negedge clk);
    start = 1'b1; funct = f; rs_val = a; rt_val = b;
    @(negedge clk);
    nb0 = busy ? 1 : 0;
    start = 1'b0;
    rs_val = $urandom;   // operands must already be captured
    rt_val = $urandom;
    wait_done(nb1);
    check("busy_cycles", nb0 + nb1, 33);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 0);
  endtask

  initial begin
    int nb;
    int ndone;

    repeat (3) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    rst = 1'b0;

    run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op(F_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op(F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    run_op(F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op(F_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b0);
    run_op(F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0);
    run_op(F_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1);
    run_op(F_DIV,   32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 1'b0);

    // MTHI while busy must be ignored.
    expq.push_back('{hi: 32'd0, lo: 32'd30, dz: 1'b0});
    @(negedge clk);
    start = 1'b1; funct = F_MULT; rs_val = 32'd5; rt_val = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; funct = F_MTHI; rs_val = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    wait_done(nb);
    @(negedge clk);

    // MTHI / MTLO when idle: one edge, no done.
    start = 1'b1; funct = F_MTHI; rs_val = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    check("mthi_hi", hi, 32'h1234);
    check("mthi_lo_kept", lo, 32'd30);
    check("mthi_no_done", {31'd0, done}, 0);
    check("mthi_no_busy", {31'd0, busy}, 0);
    start = 1'b1; funct = F_MTLO; rs_val = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_lo", lo, 32'h5678);
    check("mtlo_hi_kept", hi, 32'h1234);

    // Illegal funct: no state change.
    start = 1'b1; funct = 6'h20; rs_val = 32'hDEAD; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("illegal_busy", {31'd0, busy}, 0);
    check("illegal_hi", hi, 32'h1234);
    check("illegal_lo", lo, 32'h5678);

    // Reset in the middle of a divide.
    start = 1'b1; funct = F_DIVU; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);

    // Back-to-back with start held high.
    expq.push_back('{hi: 32'd0, lo: 32'd6, dz: 1'b0});
    expq.push_back('{hi: 32'd1, lo: 32'd2, dz: 1'b0});
    start = 1'b1; funct = F_MULTU; rs_val = 32'd2; rt_val = 32'd3;
    @(negedge clk);
    funct = F_DIVU; rs_val = 32'd9; rt_val = 32'd4;
    wait_done(nb);
    @(negedge clk);
    check("b2b_busy", {31'd0, busy}, 1);
    start = 1'b0;
    wait_done(nb);
    check("b2b_busy_cycles", nb + 1, 33);
    @(negedge clk);
    check("b2b_final_hi", hi, 32'd1);
    check("b2b_final_lo", lo, 32'd2);

    repeat (2) @(negedge clk);
    check("queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit: the next-generation execution companion to the ALU decoder. It decodes the R-type MULT/MULTU/DIV/DIVU/MTHI/MTLO funct codes itself and runs multi-cycle radix-2 shift-add multiply and restoring divide over a parameterised datapath. Results go to architectural HI/LO registers. The core control stalls on `busy`, and MFHI/MFLO read `hi`/`lo` directly.

## Interface
- `WIDTH`, 32, operand and HI/LO width; must be ≥ 2.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; sampled only when `busy`=0.
- `funct` in 6: R-type function field, sampled with `start`.
- `rs_val` in WIDTH: multiplicand or dividend (MTHI/MTLO source).
- `rt_val` in WIDTH: multiplier or divisor.
- `busy` out 1: operation in flight; the core must stall.
- `done` out 1: one-cycle pulse; `hi`/`lo` valid and new.
- `dz` out 1: divide-by-zero flag; valid while `done`=1, else 0.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- Accepted funct codes:
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011 (multi-cycle).
  - MTHI 010001, MTLO 010011 (single-cycle writes).
- Any other funct with `start`=1 is ignored; there is no state change.
- A request is accepted at an edge where `start`=1, `busy`=0, and `funct` is legal.
- `start` while `busy`=1 is ignored. This includes MTHI/MTLO; no queueing.
- MTHI/MTLO: the accept edge writes `rs_val` to `hi`/`lo`. `busy` stays 0, no `done` pulse.
- States:
  - IDLE.
  - MUL: WIDTH iterations.
  - DIV: WIDTH iterations.
  - FIX: sign correction and HI/LO write.
- Transitions:
  - IDLE→MUL/DIV on accept.
  - MUL/DIV→FIX after iteration count reaches WIDTH−1.
  - FIX→IDLE unconditionally.
- At accept, operands are captured. Later changes on `rs_val`/`rt_val` have no effect.
- Signed ops store magnitudes plus result sign flags. Unsigned ops store operands as-is.
- Multiply:
  - Uses a 2·WIDTH-bit product.
  - Signed result is negated in FIX when operand signs differ.
  - `hi` = product[2W−1:W], `lo` = product[W−1:0].
- Divide:
  - Restoring, one quotient bit per iteration.
  - Quotient is negative when signs differ. Remainder sign follows the dividend.
  - `lo` = quotient, `hi` = remainder.
- Overflow: DIV of −2^(W−1) by −1 wraps, giving `lo` = 0x80..0 and `hi` = 0. No flag is raised.
- Divide by zero (`rt_val`=0 at accept), DIV or DIVU:
  - Iterations still run; latency is unchanged.
  - FIX forces `lo` = all ones and `hi` = captured `rs_val`.
  - `dz`=1 with `done`.
- `hi`/`lo` change only at the FIX→IDLE edge or an MTHI/MTLO accept. They hold otherwise.
- `rst` (any state, including mid-operation): IDLE, counter 0, `hi`=`lo`=0, `busy`=`done`=`dz`=0. An in-flight result is discarded.
- `rst` has priority over `start` in the same cycle.

## Timing
- All outputs are registered.
- Accept at edge E0: `busy`=1 from after E0 through the cycle before E0+WIDTH+1.
- Iterations run on edges E0+1 … E0+WIDTH. FIX is the cycle after E0+WIDTH.
- At edge E0+WIDTH+1: `hi`/`lo` are written, `busy`→0, and `done`→1 (with `dz` if applicable) for exactly one cycle.
- Total latency is WIDTH+1 cycles from accept to results visible (33 for WIDTH=32).
- A new `start` may be accepted on the same edge where `done` is high, i.e. back-to-back with no gap cycle.
- MTHI/MTLO latency is 1 edge.

## Test plan
- MULTU, 0xFFFFFFFF × 0xFFFFFFFF, WIDTH=32:
  - `busy` is high for 33 cycles, then `done` pulses.
  - `hi`=0xFFFFFFFE, `lo`=0x00000001.
- MULT: −3 × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. Then MULT 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0.
- Divide signs and overflow:
  - DIV −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU 7/2 → `lo`=3, `hi`=1.
  - DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `dz`=0.
- DIVU 5/0 → after 33 cycles, `lo`=0xFFFFFFFF, `hi`=5, `dz`=1 for one cycle only.
- Request gating:
  - Start MULT. At cycle 5, assert `start` with MTHI 0x1234 → ignored; the final `hi` is the product, not 0x1234.
  - After `done`, MTHI 0x1234 → `hi`=0x1234 next cycle with no `done` pulse.
  - Illegal funct 0x20 with `start` → no change.
- Reset mid-operation: assert `rst` at cycle 10 of a DIV → next cycle `busy`=0, `hi`=`lo`=0, and no `done` follows.
- Back-to-back: `start` held high with MULTU 2×3 then DIVU 9/4 → second accept on the `done` edge; the final result is `lo`=2, `hi`=1.
